// File: rtl/multi_tap_delay.sv
// -----------------------------------------------------------------------------
// multi_tap_delay
//
// One mono sample stream is written into a shared circular buffer. CHANNELS
// independent taps read it back, each with its own delay (in samples) and its
// own gain (unsigned, 128 = unity). The taps are serviced one per clock cycle
// after every sample_en strobe, and all tap results are presented together.
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   sample_en    one-cycle strobe: sample_in holds a new sample
//   sample_in    signed input sample
//   delay_flat   per-channel delay, channel k at [k*DW +: DW]
//   gain_flat    per-channel gain, channel k at [k*8 +: 8], 128 = unity
//   samples_out  per-channel delayed, scaled sample, channel k at [k*WIDTH +: WIDTH]
//   out_valid    one-cycle pulse when samples_out has just been updated
//   busy         high while a sample is being processed
//   overrun      sticky: a sample_en arrived while busy (that sample was dropped)
// -----------------------------------------------------------------------------
module multi_tap_delay #(
  parameter  int CHANNELS = 6,
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 1024,
  localparam int DW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_en,
  input  logic signed [WIDTH-1:0]   sample_in,
  input  logic [CHANNELS*DW-1:0]    delay_flat,
  input  logic [CHANNELS*8-1:0]     gain_flat,
  output logic [CHANNELS*WIDTH-1:0] samples_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = WIDTH + 9;  // product width: WIDTH x signed 9-bit gain

  localparam logic [DW:0]          FILL_MAX = (DW+1)'(DEPTH);
  localparam logic signed [PW-1:0] ROUND    = PW'(64);
  localparam logic signed [PW-1:0] SAT_MAX  = PW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN  = PW'(-(1 << (WIDTH-1)));

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     accept, issue, finish;

  logic [DW-1:0]            wr_ptr_q, base_q;
  logic [DW:0]              fill_q;            // saturates at DEPTH
  logic [CW-1:0]            ch_q;
  logic [DW-1:0]            delay_q [CHANNELS];
  logic [7:0]               gain_q  [CHANNELS];

  logic signed [WIDTH-1:0]  mem [DEPTH];
  logic signed [WIDTH-1:0]  rd_data_q;
  logic                     rd_valid_q, rd_zero_q;
  logic [CW-1:0]            rd_ch_q;
  logic signed [WIDTH-1:0]  shadow_q [CHANNELS];
  logic                     out_valid_q, overrun_q;

  logic [DW-1:0]            cur_delay, rd_addr;

  // Scale by gain/128 with round-half-up, then saturate to the sample range.
  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] s,
                                                    input logic [7:0]              g);
    logic signed [PW-1:0] p, r;
    p = s * $signed({1'b0, g});
    r = (p + ROUND) >>> 7;
    if (r > SAT_MAX)      scale = SAT_MAX[WIDTH-1:0];
    else if (r < SAT_MIN) scale = SAT_MIN[WIDTH-1:0];
    else                  scale = r[WIDTH-1:0];
  endfunction

  // A DW-bit delay field can never exceed DEPTH-1, so no explicit clamp is
  // needed; subtraction wraps modulo DEPTH because DEPTH is a power of two.
  assign cur_delay = delay_q[ch_q];
  assign rd_addr   = base_q - cur_delay;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (sample_en) begin
        accept  = 1'b1;
        state_d = READ;
      end
      READ: begin
        issue = 1'b1;
        if (ch_q == CW'(CHANNELS-1)) state_d = DONE;
      end
      // The last tap result lands in its shadow register on the edge where
      // rd_valid_q drops; the following edge publishes all of them together.
      DONE: if (!rd_valid_q) begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the sample RAM has no reset so it maps onto block RAM; stale
  // contents are harmless because fill_q masks unwritten positions.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= sample_in;
    rd_data_q <= mem[rd_addr];
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      fill_q      <= '0;
      ch_q        <= '0;
      delay_q     <= '{default: '0};
      gain_q      <= '{default: '0};
      rd_valid_q  <= 1'b0;
      rd_zero_q   <= 1'b0;
      rd_ch_q     <= '0;
      shadow_q    <= '{default: '0};
      samples_out <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= finish;

      // A strobe while busy is dropped; the running operation continues.
      if (sample_en && (state_q != IDLE)) overrun_q <= 1'b1;

      if (accept) begin
        base_q   <= wr_ptr_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
        ch_q     <= '0;
        for (int k = 0; k < CHANNELS; k++) begin
          delay_q[k] <= delay_flat[k*DW +: DW];
          gain_q[k]  <= gain_flat[k*8 +: 8];
        end
      end

      // ch_q stops on the last channel so it always indexes a real tap.
      if (issue && (state_d == READ)) ch_q <= ch_q + 1'b1;

      // Control bits travel alongside the registered RAM read.
      rd_valid_q <= issue;
      rd_ch_q    <= ch_q;
      rd_zero_q  <= ({1'b0, cur_delay} >= fill_q);

      if (rd_valid_q)
        shadow_q[rd_ch_q] <= rd_zero_q ? '0 : scale(rd_data_q, gain_q[rd_ch_q]);

      if (finish)
        for (int k = 0; k < CHANNELS; k++)
          samples_out[k*WIDTH +: WIDTH] <= shadow_q[k];
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_multi_tap_delay.sv
// -----------------------------------------------------------------------------
// tb_multi_tap_delay
//
// Self-checking bench for multi_tap_delay. A behavioural model (history queue
// of accepted samples plus a countdown to the result) is compared with the DUT
// outputs after every rising edge; directed phases add literal expectations.
// -----------------------------------------------------------------------------
module tb_multi_tap_delay;

  localparam int C  = 6;
  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int DW = 10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_en;
  logic signed [W-1:0] sample_in;
  logic [C*DW-1:0]    delay_flat;
  logic [C*8-1:0]     gain_flat;
  logic [C*W-1:0]     samples_out;
  logic               out_valid, busy, overrun;

  multi_tap_delay #(.CHANNELS(C), .WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .sample_in  (sample_in),
    .delay_flat (delay_flat),
    .gain_flat  (gain_flat),
    .samples_out(samples_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ch(input int k);
    logic signed [W-1:0] v;
    v = samples_out[k*W +: W];
    return int'(v);
  endfunction

  task automatic set_tap(input int k, input int d, input int g);
    delay_flat[k*DW +: DW] = DW'(d);
    gain_flat[k*8 +: 8]    = 8'(g);
  endtask

  // ---------------- behavioural reference model ----------------
  int m_hist[$];       // accepted samples since reset, newest last, at most D kept
  int m_cnt;           // cycles until the pending result is published
  int m_pend[C];
  int m_out[C];
  bit m_valid, m_ov;

  function automatic int scale_ref(input int s, input int g);
    int r;
    r = (s * g + 64) >>> 7;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic void model_reset();
    m_hist.delete();
    m_cnt = 0;
    m_valid = 0;
    m_ov = 0;
    for (int k = 0; k < C; k++) begin
      m_pend[k] = 0;
      m_out[k]  = 0;
    end
  endfunction

  initial begin
    logic            e_en, e_rst, was_busy;
    logic [W-1:0]    e_in;
    logic [C*DW-1:0] e_dl;
    logic [C*8-1:0]  e_gn;
    model_reset();
    forever begin
      @(posedge clk);
      e_en = sample_en; e_in = sample_in; e_dl = delay_flat; e_gn = gain_flat; e_rst = rst_n;
      #1;
      if (!e_rst) model_reset();
      else begin
        was_busy = (m_cnt > 0);
        m_valid = 0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_valid = 1;
            m_out = m_pend;
          end
        end
        if (e_en) begin
          if (was_busy) m_ov = 1;
          else begin
            m_hist.push_back(int'($signed(e_in)));
            if (m_hist.size() > D) void'(m_hist.pop_front());
            for (int k = 0; k < C; k++) begin
              int d, g, v;
              d = int'(e_dl[k*DW +: DW]);
              g = int'(e_gn[k*8 +: 8]);
              v = (d < m_hist.size()) ? m_hist[m_hist.size()-1-d] : 0;
              m_pend[k] = scale_ref(v, g);
            end
            m_cnt = C + 2;
          end
        end
      end
      check("cyc out_valid", out_valid, m_valid);
      check("cyc busy", busy, m_cnt > 0);
      check("cyc overrun", overrun, m_ov);
      for (int k = 0; k < C; k++) check($sformatf("cyc samples_out ch%0d", k), ch(k), m_out[k]);
    end
  end

  // ---------------- directed / random stimulus ----------------
  task automatic wait_valid(output int busy_cycles);
    bit got;
    busy_cycles = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        got = 1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    if (!got) check("out_valid timeout", 0, 1);
  endtask

  task automatic strobe(input int value, output int busy_cycles);
    @(negedge clk);
    sample_en = 1'b1;
    sample_in = W'(value);
    @(negedge clk);
    sample_en = 1'b0;
    wait_valid(busy_cycles);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int bc, v, seen;
    int ramp_d[C]  = '{0, 1, 2, 5, 10, 19};
    int gains[C]   = '{0, 64, 128, 255, 128, 128};
    int g_pos[C]   = '{0, 10000, 20000, 32767, 20000, 20000};
    int g_neg[C]   = '{0, -10000, -20000, -32768, -20000, -20000};

    rst_n = 1'b0; sample_en = 1'b0; sample_in = '0; delay_flat = '0; gain_flat = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    check("reset samples_out", samples_out, 0);
    rst_n = 1'b1;

    // Unity pass-through and latency.
    for (int k = 0; k < C; k++) set_tap(k, 0, 128);
    strobe(1000, bc);
    for (int k = 0; k < C; k++) check($sformatf("unity ch%0d", k), ch(k), 1000);
    check("busy cycles", bc, C + 2);

    // Ramp with fixed delays; fill masking for early strobes.
    do_reset();
    for (int k = 0; k < C; k++) set_tap(k, ramp_d[k], 128);
    for (int n = 1; n <= 20; n++) begin
      strobe(n, bc);
      for (int k = 0; k < C; k++)
        check($sformatf("ramp n%0d ch%0d", n, k), ch(k), (n > ramp_d[k]) ? n - ramp_d[k] : 0);
      if (n == 3) check("fill mask strobe3 ch3", ch(3), 0);
    end

    // Gain scaling and saturation.
    for (int k = 0; k < C; k++) set_tap(k, 0, gains[k]);
    strobe(20000, bc);
    for (int k = 0; k < C; k++) check($sformatf("gain +20000 ch%0d", k), ch(k), g_pos[k]);
    strobe(-20000, bc);
    for (int k = 0; k < C; k++) check($sformatf("gain -20000 ch%0d", k), ch(k), g_neg[k]);

    // Longest delay across the write-pointer wrap.
    do_reset();
    set_tap(0, D - 1, 128);
    set_tap(1, D - 1, 128);
    set_tap(2, 0, 128);
    for (int k = 3; k < C; k++) set_tap(k, $urandom_range(0, D - 1), $urandom_range(0, 255));
    for (int i = 0; i < 1100; i++) begin
      strobe(i * 13 + 5, bc);
      if (i == 1022) check("max delay not yet filled", ch(0), 0);
      if (i == 1023) check("max delay oldest", ch(1), 5);
      if (i == 1099) begin
        check("max delay after wrap", ch(0), 993);
        check("zero delay after wrap", ch(2), 14292);
      end
    end

    // Strobe while busy: dropped, overrun sticky.
    do_reset();
    for (int k = 0; k < C; k++) set_tap(k, (k == 1) ? 1 : 0, 128);
    @(negedge clk); sample_en = 1'b1; sample_in = 16'sd111;
    @(negedge clk); sample_en = 1'b0;
    @(negedge clk); sample_en = 1'b1; sample_in = 16'sd222;
    @(negedge clk); sample_en = 1'b0;
    wait_valid(bc);
    check("overrun first ch0", ch(0), 111);
    check("overrun set", overrun, 1);
    strobe(333, bc);
    check("after drop ch0", ch(0), 333);
    check("after drop ch1", ch(1), 111);
    check("overrun held", overrun, 1);

    // Reset in the middle of an operation.
    @(negedge clk); sample_en = 1'b1; sample_in = 16'sd777;
    @(negedge clk); sample_en = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-op busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    check("abort overrun", overrun, 0);
    check("abort samples_out", samples_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no pulse after abort", seen, 0);
    for (int k = 0; k < C; k++) set_tap(k, (k == 1) ? 0 : 1, 128);
    strobe(500, bc);
    check("post-reset delay1 ch0", ch(0), 0);
    check("post-reset delay0 ch1", ch(1), 500);

    // Randomised traffic, including occasional too-close strobes.
    for (int i = 0; i < 300; i++) begin
      int gap;
      for (int k = 0; k < C; k++)
        set_tap(k, ($urandom_range(0, 7) == 0) ? D - 1 : $urandom_range(0, 40), $urandom_range(0, 255));
      v = $urandom_range(0, 65535) - 32768;
      @(negedge clk); sample_en = 1'b1; sample_in = W'(v);
      @(negedge clk); sample_en = 1'b0;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(8, 14);
      repeat (gap) @(negedge clk);
    end
    repeat (C + 6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
